// File: rtl/if_id_buffer_pkg.sv
// rtl/if_id_buffer_pkg.sv - shared widths, entry type and bench constants for the IF/ID buffer
package if_id_buffer_pkg;

  localparam int RNG_32 = 32;
  localparam int RNG_64 = 64;

  // One fetched pair as it sits in the buffer: PC in the upper bits, instruction below
  typedef struct packed {
    logic [RNG_64-1:0] pc;
    logic [RNG_32-1:0] instr;
  } if_id_entry_t;

  // First fetch address used by benches after reset
  localparam logic [15:0] RESET_PC = 16'h100;

endpackage

// File: rtl/if_id_buffer_sync_fifo.sv
// rtl/if_id_buffer_sync_fifo.sv - generic DEPTH x WIDTH synchronous FIFO with clear
module if_id_buffer_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state pointers and occupancy; clear wins over push/pop, push+pop keeps count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since empty entries are never shown
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - IF-to-ID fetch buffer with skid reserve, flush and sticky overflow (IF_ID_PERF_EN adds counters)
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int SKID    = 1,
  parameter int PC_W    = RNG_64,
  parameter int INSTR_W = RNG_32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] i_if_instr,
  input  logic [PC_W-1:0]    i_if_pc,
  input  logic               i_if_valid_instr,
  output logic               o_id_ready,
  input  logic               i_flush,
  output logic [INSTR_W-1:0] o_id_instr,
  output logic [PC_W-1:0]    o_id_pc,
  output logic               o_id_valid,
  input  logic               i_dec_ready,
`ifdef IF_ID_PERF_EN
  output logic [31:0]        o_stall_cnt,
  output logic [31:0]        o_flush_drop_cnt,
`endif
  output logic               o_overflow
);

  localparam int W     = PC_W + INSTR_W;
  localparam int CNT_W = $clog2(DEPTH + 1);
  // Ready drops early enough that the fetch already in flight still finds room
  localparam logic [CNT_W-1:0] READY_LIM = CNT_W'(DEPTH - SKID);

  logic [W-1:0]     fifo_rdata;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             overflow_q, overflow_d;

  // A pop in the same cycle frees a slot, so a full buffer still accepts a push then
  assign pop  = ~fifo_empty & i_dec_ready & ~i_flush;
  assign push = i_if_valid_instr & ~i_flush & (~fifo_full | pop);

  if_id_buffer_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (i_flush),
    .wdata_i ({i_if_pc, i_if_instr}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Ready is a function of registered occupancy only, keeping IF's PC select loop-free
  assign o_id_ready = (fifo_count < READY_LIM);
  assign o_id_valid = ~fifo_empty;
  assign {o_id_pc, o_id_instr} = fifo_empty ? '0 : fifo_rdata;
  assign o_overflow = overflow_q;

  // Overflow latches when a fetch is dropped against a full, non-draining buffer
  always_comb begin
    overflow_d = overflow_q | (i_if_valid_instr & ~i_flush & fifo_full & ~pop);
  end

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_drop_q, flush_drop_d;
  logic [32:0] drop_sum;

  // Saturating stall and flushed-entry counters
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_drop_d = flush_drop_q;
    drop_sum     = {1'b0, flush_drop_q} + 33'(fifo_count);
    if (!o_id_ready && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
    if (i_flush) flush_drop_d = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
  end

  // Performance counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      flush_drop_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_drop_q <= flush_drop_d;
    end
  end

  assign o_stall_cnt      = stall_cnt_q;
  assign o_flush_drop_cnt = flush_drop_q;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// tb/tb_if_id_buffer.sv - directed self-checking bench for if_id_buffer
module tb_if_id_buffer;
  import if_id_buffer_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] i_if_instr;
  logic [63:0] i_if_pc;
  logic        i_if_valid_instr;
  logic        o_id_ready;
  logic        i_flush;
  logic [31:0] o_id_instr;
  logic [63:0] o_id_pc;
  logic        o_id_valid;
  logic        i_dec_ready;
  logic        o_overflow;
`ifdef IF_ID_PERF_EN
  logic [31:0] o_stall_cnt;
  logic [31:0] o_flush_drop_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  if_id_buffer #(
    .DEPTH   (4),
    .SKID    (1),
    .PC_W    (64),
    .INSTR_W (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_if_instr       (i_if_instr),
    .i_if_pc          (i_if_pc),
    .i_if_valid_instr (i_if_valid_instr),
    .o_id_ready       (o_id_ready),
    .i_flush          (i_flush),
    .o_id_instr       (o_id_instr),
    .o_id_pc          (o_id_pc),
    .o_id_valid       (o_id_valid),
    .i_dec_ready      (i_dec_ready),
`ifdef IF_ID_PERF_EN
    .o_stall_cnt      (o_stall_cnt),
    .o_flush_drop_cnt (o_flush_drop_cnt),
`endif
    .o_overflow       (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct instruction per PC; PC 0x100 maps to 0x00000013
  function automatic logic [31:0] ins(input logic [63:0] pc);
    return 32'h13 + ((pc[31:0] - 32'h100) << 10);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc);
    i_if_valid_instr = v;
    i_if_pc          = pc;
    i_if_instr       = ins(pc);
  endtask

  task automatic head(input string tag, input logic [63:0] pc);
    chk({tag, "_valid"}, 64'(o_id_valid), 64'd1);
    chk({tag, "_pc"}, o_id_pc, pc);
    chk({tag, "_instr"}, 64'(o_id_instr), 64'(ins(pc)));
  endtask

  initial begin
    rst = 1'b1;
    i_flush = 1'b0;
    i_dec_ready = 1'b0;
    drive(1'b0, 64'h0);
    step();
    step();
    chk("rst_valid", 64'(o_id_valid), 64'd0);
    chk("rst_instr", 64'(o_id_instr), 64'd0);
    chk("rst_pc", o_id_pc, 64'd0);
    chk("rst_ovf", 64'(o_overflow), 64'd0);
`ifdef IF_ID_PERF_EN
    chk("rst_stall", 64'(o_stall_cnt), 64'd0);
    chk("rst_fdrop", 64'(o_flush_drop_cnt), 64'd0);
`endif
    rst = 1'b0;
    #1;
    chk("rel_ready", 64'(o_id_ready), 64'd1);

    // single push, one-cycle latency, then drained
    i_dec_ready = 1'b1;
    drive(1'b1, 64'(RESET_PC));
    step();
    head("t1", 64'h100);
    chk("t1_instr13", 64'(o_id_instr), 64'h13);
    drive(1'b0, 64'h0);
    step();
    chk("t1_empty", 64'(o_id_valid), 64'd0);
    chk("t1_zero_pc", o_id_pc, 64'd0);

    // fill with decoder stalled; ready drops at count 3, skid slot takes 0x10C
    i_dec_ready = 1'b0;
    drive(1'b1, 64'h100);
    step();
    chk("t2_rdy1", 64'(o_id_ready), 64'd1);
    drive(1'b1, 64'h104);
    step();
    chk("t2_rdy2", 64'(o_id_ready), 64'd1);
    drive(1'b1, 64'h108);
    step();
    chk("t2_rdy3", 64'(o_id_ready), 64'd0);
    drive(1'b1, 64'h10C);
    step();
    chk("t2_rdy4", 64'(o_id_ready), 64'd0);
    chk("t2_ovf", 64'(o_overflow), 64'd0);
    head("t2_head", 64'h100);

    // push while full and stalled: dropped, overflow sticks
    drive(1'b1, 64'h110);
    step();
    chk("t3_ovf", 64'(o_overflow), 64'd1);
    head("t3_head", 64'h100);

    // push and pop while full: count stays 4, 0x110 lands at the tail
    i_dec_ready = 1'b1;
    drive(1'b1, 64'h110);
    step();
    head("t4_head", 64'h104);
    chk("t4_rdy", 64'(o_id_ready), 64'd0);
    drive(1'b0, 64'h0);
    step();
    head("t4_p108", 64'h108);
    chk("t4_rdy3", 64'(o_id_ready), 64'd0);
    step();
    head("t4_p10c", 64'h10C);
    chk("t4_rdy2", 64'(o_id_ready), 64'd1);
    step();
    head("t4_p110", 64'h110);
    step();
    chk("t4_empty", 64'(o_id_valid), 64'd0);
    chk("t4_ovf_sticky", 64'(o_overflow), 64'd1);

    // flush at count 3 with a same-cycle fetch of 0x200
    i_dec_ready = 1'b0;
    drive(1'b1, 64'h300);
    step();
    drive(1'b1, 64'h304);
    step();
    drive(1'b1, 64'h308);
    step();
    head("t5_pre", 64'h300);
    i_dec_ready = 1'b1;
    drive(1'b1, 64'h200);
    i_flush = 1'b1;
    step();
    chk("t5_valid", 64'(o_id_valid), 64'd0);
    chk("t5_ready", 64'(o_id_ready), 64'd1);
    chk("t5_pc", o_id_pc, 64'd0);
`ifdef IF_ID_PERF_EN
    chk("t5_fdrop", 64'(o_flush_drop_cnt), 64'd3);
`endif
    step();
    chk("t5_b2b", 64'(o_id_valid), 64'd0);
    i_flush = 1'b0;
    drive(1'b0, 64'h0);
    step();
    chk("t5_not_stored", 64'(o_id_valid), 64'd0);
    drive(1'b1, 64'h400);
    step();
    head("t5_post", 64'h400);

    // async reset with two entries buffered
    i_dec_ready = 1'b0;
    drive(1'b1, 64'h404);
    step();
    drive(1'b0, 64'h0);
    head("t6_pre", 64'h400);
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 64'(o_id_valid), 64'd0);
    chk("t6_async_ovf", 64'(o_overflow), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("t6_ready", 64'(o_id_ready), 64'd1);
    chk("t6_empty", 64'(o_id_valid), 64'd0);
    drive(1'b1, 64'h500);
    step();
    head("t6_first", 64'h500);
    drive(1'b0, 64'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
